// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the mem_arbiter block.
//   state_e : arbiter FSM encodings (IDLE=0, BUSY=1)
//   port_e  : requester ids (PORT_I = instruction fetch, PORT_D = data access)
//   req_t   : request latched at grant and replayed to mem_system while BUSY
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    port_e       port;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]  in  request vector, bit 0 = fetch port, bit 1 = data port
//   last      in  port id granted most recently
//   enable    in  arbitration allowed this cycle
//   gnt[1:0]  out one-hot grant (all zero when disabled or idle)
//   next_last out value of last after this cycle's grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       next_last
);

  always_comb begin
    gnt       = 2'b00;
    next_last = last;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Tie: the port that did not win last time goes first.
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
      if (gnt != 2'b00) next_last = gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch port and the data port.
// One access in flight at a time: a request is granted in IDLE, latched,
// and replayed on the mem_* pins for every BUSY cycle until mem_Done.
// Completion is a registered one-cycle done pulse with read data.
// A watchdog turns a hung access into an error completion (data 0).
//   clk, rst                         clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt/i_done/i_data            fetch port (read only)
//   d_req/d_wr/d_addr/d_wdata -> d_gnt/d_done/d_rdata   data port
//   mem_Addr/mem_DataIn/mem_Rd/mem_Wr                   to mem_system
//   mem_DataOut/mem_Done/mem_err                        from mem_system
//   err                              sticky error, cleared only by rst
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_done,
  output logic [15:0] i_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        mem_Rd,
  output logic        mem_Wr,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_err,
  output logic        err
);

  state_e           state_q, state_d;
  port_e            last_q, last_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             err_q, err_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [15:0]      i_data_q, i_data_d;
  logic [15:0]      d_rdata_q, d_rdata_d;

  logic [1:0] arb_req, arb_gnt;
  logic       arb_next_last;
  logic       arb_en;
  logic       accept, busy, timeout_hit, complete;

  assign arb_req = {d_req, i_req};
  assign arb_en  = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .req      (arb_req),
    .last     (last_q),
    .enable   (arb_en),
    .gnt      (arb_gnt),
    .next_last(arb_next_last)
  );

  assign busy   = (state_q == ST_BUSY);
  assign accept = |arb_gnt;
  // mem_Done in the watchdog's last cycle wins: that is a normal completion.
  assign timeout_hit = busy && !mem_Done && (wd_q == CNT_W'(TIMEOUT - 1));
  assign complete    = busy && (mem_Done || timeout_hit);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)   state_d = ST_BUSY;
      ST_BUSY: if (complete) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // mem_* are idle-low outside BUSY so mem_system sees a gap between accesses.
  always_comb begin
    i_gnt      = arb_gnt[0];
    d_gnt      = arb_gnt[1];
    mem_Addr   = 16'h0000;
    mem_DataIn = 16'h0000;
    mem_Rd     = 1'b0;
    mem_Wr     = 1'b0;
    if (busy) begin
      mem_Addr   = req_q.addr;
      mem_DataIn = req_q.wdata;
      mem_Rd     = !req_q.wr;
      mem_Wr     = req_q.wr;
    end
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    req_d     = req_q;
    last_d    = last_q;
    wd_d      = wd_q;
    err_d     = err_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;

    if (accept) begin
      last_d = port_e'(arb_next_last);
      wd_d   = '0;
      if (arb_gnt[1]) begin
        req_d = '{addr: d_addr, wdata: d_wdata, wr: d_wr, port: PORT_D};
      end else begin
        // Fetches are always reads with a zero data bus.
        req_d = '{addr: i_addr, wdata: 16'h0000, wr: 1'b0, port: PORT_I};
      end
    end

    if (busy) wd_d = wd_q + CNT_W'(1);

    if (busy && (mem_err || timeout_hit)) err_d = 1'b1;

    if (complete) begin
      if (req_q.port == PORT_I) begin
        i_done_d = 1'b1;
        i_data_d = mem_Done ? mem_DataOut : 16'h0000;
      end else begin
        d_done_d  = 1'b1;
        d_rdata_d = (mem_Done && !req_q.wr) ? mem_DataOut : 16'h0000;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '{addr: 16'h0000, wdata: 16'h0000, wr: 1'b0, port: PORT_I};
      last_q    <= PORT_I;
      wd_q      <= '0;
      err_q     <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_data_q  <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      req_q     <= req_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural mem_system responder
// answers after a programmable number of BUSY cycles (or never); expected
// completions are queued at grant time and matched against observed done
// pulses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_done;
  logic [15:0] i_addr, i_data;
  logic        d_req, d_wr, d_gnt, d_done;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [15:0] mem_Addr, mem_DataIn, mem_DataOut;
  logic        mem_Rd, mem_Wr, mem_Done, mem_err, err;

  typedef struct packed {
    logic        port;  // 0 = fetch, 1 = data
    logic [15:0] data;
  } cpl_t;

  cpl_t exp_q[$];
  cpl_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // responder configuration
  int          lat     = 1;
  int          err_at  = 0;
  bit          hang    = 1'b0;
  logic [15:0] xor_key = 16'h5A5A;
  int          busy_cnt = 0;

  mem_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_data(i_data),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_err(mem_err), .err(err)
  );

  initial forever #5 clk = ~clk;

  // mem_system model: counts request cycles, answers with addr ^ xor_key.
  initial begin
    mem_Done = 1'b0; mem_err = 1'b0; mem_DataOut = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst && (mem_Rd || mem_Wr)) begin
        busy_cnt++;
        mem_Done    = (!hang && busy_cnt == lat);
        mem_err     = (err_at != 0 && busy_cnt == err_at);
        mem_DataOut = mem_Addr ^ xor_key;
      end else begin
        busy_cnt = 0; mem_Done = 1'b0; mem_err = 1'b0; mem_DataOut = 16'h0000;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // Advance one cycle; record any completions the DUT produced.
  task automatic step();
    @(posedge clk);
    #1;
    if (i_done) obs_q.push_back({1'b0, i_data});
    if (d_done) obs_q.push_back({1'b1, d_rdata});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({i_gnt, d_gnt, i_done, d_done, mem_Rd, mem_Wr, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {i_gnt, d_gnt, i_done, d_done, mem_Rd, mem_Wr, err});
    end
    n_checks++;
    if ({i_data, d_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h required 00000000", {i_data, d_rdata});
    end
    n_checks++;
    if ({mem_Addr, mem_DataIn} !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem: got %h required 00000000", {mem_Addr, mem_DataIn});
    end
    rst = 1'b0;
    obs_q.delete();
    $display("reset: outputs checked after synchronous reset");
  endtask

  task automatic test_single_fetch();
    cpl_t e, o;
    lat = 2; xor_key = 16'h1274;  // 0x0040 ^ 0x1274 = 0x1234
    d_wdata = 16'hDEAD;
    i_addr = 16'h0040; i_req = 1'b1;
    #1;
    n_checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_gnt: got %b required 10", {i_gnt, d_gnt});
    end
    exp_q.push_back({1'b0, 16'h1234});
    step(); i_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if ({mem_Rd, mem_Wr, mem_Addr, mem_DataIn, i_done} !== {2'b10, 16'h0040, 16'h0000, 1'b0}) begin
        n_fail++;
        $display("FAIL fetch_mem_t%0d: got Rd=%b Wr=%b A=%h D=%h done=%b required Rd=1 Wr=0 A=0040 D=0000 done=0",
                 k, mem_Rd, mem_Wr, mem_Addr, mem_DataIn, i_done);
      end
      step();
    end
    n_checks++;
    if ({i_done, i_data, mem_Rd} !== {1'b1, 16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_done_t3: got done=%b data=%h Rd=%b required done=1 data=1234 Rd=0",
               i_done, i_data, mem_Rd);
    end
    step();
    n_checks++;
    if ({i_done, i_data} !== {1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL fetch_hold: got done=%b data=%h required done=0 data=1234", i_done, i_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL fetch_sb: got none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL fetch_sb: got %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL fetch_sb_extra: got %0d extra required 0", obs_q.size()); obs_q.delete();
    end
    $display("single_fetch: addr 0040 data 1234 checked");
  endtask

  task automatic test_round_robin();
    logic seq[$];
    cpl_t e, o;
    rst = 1'b1; step(); rst = 1'b0;
    obs_q.delete();
    lat = 1; xor_key = 16'h5A5A;
    i_addr = 16'h0100; d_addr = 16'h0200; d_wr = 1'b0; d_wdata = 16'h1111;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++;
      if (i_gnt && d_gnt) begin
        n_fail++; $display("FAIL rr_both_gnt: got 11 required one-hot at cycle %0d", c);
      end
      if (i_gnt) begin seq.push_back(1'b0); exp_q.push_back({1'b0, 16'h0100 ^ 16'h5A5A}); end
      if (d_gnt) begin seq.push_back(1'b1); exp_q.push_back({1'b1, 16'h0200 ^ 16'h5A5A}); end
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    step(); step();
    n_checks++;
    if (seq.size() != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d grants required 6", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      n_checks++;
      if (seq[k] !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL rr_order_%0d: got %s required %s", k,
                           seq[k] ? "D" : "I", ((k % 2) == 0) ? "D" : "I");
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rr_sb: got none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rr_sb: got %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rr_sb_extra: got %0d extra required 0", obs_q.size()); obs_q.delete();
    end
    $display("round_robin: %0d grants checked for D,I alternation", seq.size());
  endtask

  task automatic test_write_long();
    cpl_t e, o;
    lat = 20; xor_key = 16'h5A5A;
    d_addr = 16'h0102; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    #1;
    n_checks++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL wr_gnt: got %b required 01", {i_gnt, d_gnt});
    end
    exp_q.push_back({1'b1, 16'h0000});
    step(); d_req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if ({mem_Wr, mem_Rd, mem_Addr, mem_DataIn, d_done} !== {2'b10, 16'h0102, 16'hBEEF, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_hold_t%0d: got Wr=%b Rd=%b A=%h D=%h done=%b required Wr=1 Rd=0 A=0102 D=BEEF done=0",
                 k, mem_Wr, mem_Rd, mem_Addr, mem_DataIn, d_done);
      end
      step();
    end
    n_checks++;
    if ({d_done, d_rdata, mem_Wr} !== {1'b1, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL wr_done: got done=%b rdata=%h Wr=%b required done=1 rdata=0000 Wr=0",
                         d_done, d_rdata, mem_Wr);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL wr_sb: got none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL wr_sb: got %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL wr_sb_extra: got %0d extra required 0", obs_q.size()); obs_q.delete();
    end
    d_wr = 1'b0;
    $display("write_long: addr 0102 data BEEF held 20 cycles");
  endtask

  task automatic test_mem_err();
    cpl_t e, o;
    rst = 1'b1; step(); rst = 1'b0;
    obs_q.delete();
    lat = 5; err_at = 3; xor_key = 16'h0F0F;
    i_addr = 16'h0ABC; i_req = 1'b1;
    #1;
    n_checks++;
    if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL merr_gnt: got %b required 1", i_gnt); end
    exp_q.push_back({1'b0, 16'h0ABC ^ 16'h0F0F});
    step(); i_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (err !== (k >= 4)) begin
        n_fail++; $display("FAIL merr_err_t%0d: got %b required %b", k, err, (k >= 4));
      end
      step();
    end
    n_checks++;
    if ({i_done, err} !== 2'b11) begin
      n_fail++; $display("FAIL merr_done: got done=%b err=%b required done=1 err=1", i_done, err);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL merr_sb: got none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL merr_sb: got %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL merr_sb_extra: got %0d extra required 0", obs_q.size()); obs_q.delete();
    end
    err_at = 0;
    $display("mem_err: err set, access completed with data %h", 16'h0ABC ^ 16'h0F0F);
  endtask

  task automatic test_timeout();
    cpl_t e, o;
    rst = 1'b1; step(); rst = 1'b0;
    obs_q.delete();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b required 0", err); end
    hang = 1'b1; xor_key = 16'h5A5A;
    d_addr = 16'h0300; d_wr = 1'b0; d_req = 1'b1;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL to_gnt: got %b required 1", d_gnt); end
    exp_q.push_back({1'b1, 16'h0000});
    step(); d_req = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      n_checks++;
      if ({d_done, err} !== 2'b00) begin
        n_fail++; $display("FAIL to_early_t%0d: got done=%b err=%b required 00", k, d_done, err);
      end
      step();
    end
    n_checks++;
    if ({d_done, err, d_rdata} !== {2'b11, 16'h0000}) begin
      n_fail++; $display("FAIL to_fire_t65: got done=%b err=%b rdata=%h required done=1 err=1 rdata=0000",
                         d_done, err, d_rdata);
    end
    hang = 1'b0; lat = 1;
    i_addr = 16'h0777; i_req = 1'b1;
    #1;
    n_checks++;
    if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL to_next_gnt: got %b required 1", i_gnt); end
    exp_q.push_back({1'b0, 16'h0777 ^ 16'h5A5A});
    step(); i_req = 1'b0;
    step(); step();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b required 1", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL to_sb: got none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL to_sb: got %h required %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL to_sb_extra: got %0d extra required 0", obs_q.size()); obs_q.delete();
    end
    $display("timeout: watchdog completion at cycle 65, next access normal");
  endtask

  task automatic test_reset_mid();
    lat = 10; xor_key = 16'h5A5A;
    d_addr = 16'h0444; d_wr = 1'b0; d_req = 1'b1;
    #1;
    step(); d_req = 1'b0;
    step(); step();
    n_checks++;
    if (mem_Rd !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got Rd=%b required 1", mem_Rd); end
    rst = 1'b1;
    step();
    n_checks++;
    if ({i_gnt, d_gnt, i_done, d_done, mem_Rd, mem_Wr, err, mem_Addr, mem_DataIn, i_data, d_rdata} !== 71'b0) begin
      n_fail++; $display("FAIL rmid_outputs: got Rd=%b A=%h err=%b done=%b required all zero",
                         mem_Rd, mem_Addr, err, d_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rmid_no_done: got %0d completions required 0", obs_q.size()); obs_q.delete();
    end
    $display("reset_mid: abandoned access produced no done");
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = 16'h0000;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_write_long();
    test_mem_err();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
